// File: rtl/jtframe_rst_seq.sv
// rtl/jtframe_rst_seq.sv - reset and PLL-recovery sequencer for the frame wrapper
//
// Purpose: merges RESET, PLL lock, OSD/button reset request and ROM download
// into an ordered release: PLL first, then the frame reset (rst), then the
// game reset (game_rst). game_rst is held while a request or download is active.
//
// Ports:
//   clk_sys        in   system clock (PLL output)
//   RESET          in   asynchronous active-high reset
//   pll_locked     in   PLL lock, asynchronous, synchronized internally
//   rst_req        in   level reset request, asynchronous, synchronized internally
//   downloading    in   ROM download active, asynchronous, synchronized internally
//   pll_rst        out  PLL reset, registered
//   rst / rst_n    out  frame reset and its inverse, same flop
//   game_rst / game_rst_n out game reset and its inverse, same flop
//   lock_lost_cnt  out  saturating count of lock-loss events

module jtframe_rst_seq #(
    parameter int PLL_RST_CYC = 256,
    parameter int LOCK_FILT   = 16,
    parameter int FRAME_HOLD  = 1024,
    parameter int GAME_HOLD   = 4096
) (
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic       pll_locked,
    input  logic       rst_req,
    input  logic       downloading,
    output logic       pll_rst,
    output logic       rst,
    output logic       rst_n,
    output logic       game_rst,
    output logic       game_rst_n,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_FRAMEHOLD = 3'd1,
        ST_GAMEHOLD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLLRST    = 3'd4
    } state_t;

    // Terminal counts: the counter runs 0..N-1, transition happens on the edge
    // after it shows N-1, giving exactly N cycles in the state.
    localparam logic [15:0] FILT_LAST  = 16'(LOCK_FILT - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_HOLD - 1);
    localparam logic [15:0] GAME_LAST  = 16'(GAME_HOLD - 1);
    localparam logic [15:0] PLL_LAST   = 16'(PLL_RST_CYC - 1);

    // Synchronizer bit order: {downloading, rst_req, pll_locked}
    logic [2:0]  meta_q;
    logic [2:0]  sync_q;
    logic        locked_prev_q;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  lost_q, lost_d;
    logic        pll_rst_q, pll_rst_d;
    logic        rst_q, rst_d;
    logic        game_rst_q, game_rst_d;

    logic        locked_s, req_s, dwn_s;
    logic        lock_loss;
    logic        hold_req;

    assign locked_s  = sync_q[0];
    assign req_s     = sync_q[1];
    assign dwn_s     = sync_q[2];
    assign hold_req  = req_s | dwn_s;
    // Only a 1->0 transition of the synchronized lock counts; a 0 straight
    // out of reset never produces an edge.
    assign lock_loss = locked_prev_q & ~locked_s;

    // State register, counters, synchronizers and registered outputs
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            meta_q        <= 3'b000;
            sync_q        <= 3'b000;
            locked_prev_q <= 1'b0;
            state_q       <= ST_INIT;
            cnt_q         <= 16'd0;
            lost_q        <= 8'd0;
            pll_rst_q     <= 1'b0;
            rst_q         <= 1'b1;
            game_rst_q    <= 1'b1;
        end else begin
            meta_q        <= {downloading, rst_req, pll_locked};
            sync_q        <= meta_q;
            locked_prev_q <= locked_s;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lost_q        <= lost_d;
            pll_rst_q     <= pll_rst_d;
            rst_q         <= rst_d;
            game_rst_q    <= game_rst_d;
        end
    end

    // Next-state logic: lock loss > request/download > counter expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        if (lock_loss && state_q != ST_PLLRST) begin
            state_d = ST_PLLRST;
            cnt_d   = 16'd0;
            lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!locked_s) begin
                        cnt_d = 16'd0;
                    end else if (cnt_q == FILT_LAST) begin
                        state_d = ST_FRAMEHOLD;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_FRAMEHOLD: begin
                    if (cnt_q == FRAME_LAST) begin
                        state_d = ST_GAMEHOLD;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_GAMEHOLD: begin
                    if (hold_req) begin
                        cnt_d = 16'd0;
                    end else if (cnt_q == GAME_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (hold_req) begin
                        state_d = ST_GAMEHOLD;
                        cnt_d   = 16'd0;
                    end
                end
                ST_PLLRST: begin
                    // Lock edges are ignored here; the hold always runs to term.
                    if (cnt_q == PLL_LAST) begin
                        state_d = ST_INIT;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Output decode from the next state, so outputs change on the same edge
    // as the state and come straight from flops.
    always_comb begin
        pll_rst_d  = 1'b0;
        rst_d      = 1'b1;
        game_rst_d = 1'b1;
        case (state_d)
            ST_GAMEHOLD: rst_d = 1'b0;
            ST_RUN: begin
                rst_d      = 1'b0;
                game_rst_d = 1'b0;
            end
            ST_PLLRST: pll_rst_d = 1'b1;
            default: begin
                rst_d      = 1'b1;
                game_rst_d = 1'b1;
            end
        endcase
    end

    assign pll_rst       = pll_rst_q;
    assign rst           = rst_q;
    assign rst_n         = ~rst_q;
    assign game_rst      = game_rst_q;
    assign game_rst_n    = ~game_rst_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: doc/jtframe_rst_seq.md
Name: jtframe_rst_seq

Overview:
Reset and PLL-recovery sequencer in front of the MiSTer frame wrapper, clocked by clk_sys. It merges the top-level RESET, PLL lock status, the OSD/button reset request and the ROM download flag into an ordered reset sequence. Outputs are the PLL reset, the frame reset (rst/rst_n) and the game reset (game_rst/game_rst_n). The frame reset always releases before the game reset, and the game reset stays asserted through downloads.

Parameters:
PLL_RST_CYC, 256, cycles pll_rst is held high after a lock loss (1..65535)
LOCK_FILT, 16, consecutive cycles pll_locked must read high before leaving INIT (1..255)
FRAME_HOLD, 1024, cycles rst is held after lock is qualified (1..65535)
GAME_HOLD, 4096, cycles game_rst is held after the last request/download drops (1..65535)

Ports:
clk_sys  in  1  system clock (PLL output)
RESET  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock, asynchronous to clk_sys
rst_req  in  1  level reset request (status[0] | buttons[1]), asynchronous
downloading  in  1  ROM download in progress, asynchronous
pll_rst  out  1  PLL reset, registered
rst  out  1  frame reset, registered, active-high
rst_n  out  1  inverse of rst
game_rst  out  1  game reset, registered, active-high
game_rst_n  out  1  inverse of game_rst
lock_lost_cnt  out  8  saturating count of lock-loss events

Behaviour:
- Reset is RESET, asynchronous, active-high; clock is clk_sys.
- On RESET: state=INIT, pll_rst=0, rst=1, game_rst=1, lock_lost_cnt=0, all counters=0, synchronizers=0.
- pll_locked, rst_req and downloading each pass through a 2-flop synchronizer, giving locked_s, req_s and dwn_s.
- States:
  - INIT: rst=1, game_rst=1. Filter counter increments while locked_s=1 and clears to 0 when locked_s=0. When the count reaches LOCK_FILT: go to FRAMEHOLD and clear the counter.
  - FRAMEHOLD: rst=1, game_rst=1. Count FRAME_HOLD cycles, then go to GAMEHOLD with rst=0 registered on the transition edge.
  - GAMEHOLD: rst=0, game_rst=1. The counter is cleared on every cycle where req_s|dwn_s=1. It counts only while both are 0. When the count reaches GAME_HOLD: go to RUN with game_rst=0.
  - RUN: rst=0, game_rst=0. If req_s|dwn_s=1: go to GAMEHOLD with the counter cleared. rst is not touched.
  - PLLRST: pll_rst=1, rst=1, game_rst=1. Count PLL_RST_CYC cycles, then set pll_rst=0 and go to INIT.
- Lock loss:
  - Defined as locked_s=1 on the previous cycle and locked_s=0 on this cycle.
  - In any state except PLLRST: go to PLLRST, counter cleared, lock_lost_cnt+1 saturating at 255.
  - In INIT, a lock loss also triggers PLLRST. A 0 that never followed a qualified 1 does not count as an edge.
  - Priority: lock loss > rst_req/downloading > counter expiry.
- Lock edges inside PLLRST are ignored. The counter is not restarted.
- Latency:
  - rst_req rising in RUN: game_rst=1 at the 3rd clk_sys rising edge after the input change (2 sync + 1 register).
  - pll_locked falling: pll_rst=1 at the 3rd edge.
- All outputs are registered. rst_n and game_rst_n come from the same flop, inverted, so they never glitch.
- Invariant: rst=1 implies game_rst=1 in every cycle.
- RESET asserted mid-sequence returns to INIT immediately. lock_lost_cnt is cleared.

Test Plan:
- RESET pulse, pll_locked=1 constant:
  - rst=1 and game_rst=1 on reset.
  - rst falls 2+16+1024 cycles after the synchronizer settles.
  - game_rst falls 4096 cycles after rst falls.
  - pll_rst stays 0 throughout.
- Lock glitch in INIT (locked 10 cycles high, 1 low, then high) -> PLLRST entered with lock_lost_cnt=1.
- In RUN, drop pll_locked for 5 cycles:
  - pll_rst=1 at the 3rd edge and rst=1, game_rst=1 together.
  - pll_rst held exactly 256 cycles.
  - lock_lost_cnt=1; the full sequence replays after relock.
- In RUN, pulse rst_req for 3 cycles:
  - game_rst=1 at the 3rd edge; rst stays 0.
  - game_rst falls 4096 cycles after req_s drops.
- downloading high for 10000 cycles, with a rst_req pulse inside -> game_rst held continuously; it releases 4096 cycles after dwn_s falls.
- 300 lock-loss events -> lock_lost_cnt saturates at 255; RESET mid-PLLRST returns lock_lost_cnt=0, pll_rst=0, state=INIT.
